hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline-control counterpart to the RV32I forwarding logic. It handles the hazards forwarding cannot resolve: load-use dependencies, taken-branch redirects and multi-cycle data-memory accesses. It produces per-stage stall and flush controls, and sits beside the IF/ID/EXE/MEM/WB pipeline registers. It also counts stall and flush events and flags a data-memory handshake timeout.

## Interface

Parameters
- DMEM_TIMEOUT, 16: maximum cycles spent waiting for dmem_ack before the error trap; must be ≥2.
- CNT_W, 32: width of the performance counters.

Ports
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_id  in  5  rs1 of the instruction in ID.
- rs2_id  in  5  rs2 of the instruction in ID.
- rs1_used_id  in  1  ID instruction reads rs1.
- rs2_used_id  in  1  ID instruction reads rs2.
- rd_exe  in  5  destination register of the instruction in EXE.
- mem_read_exe  in  1  EXE instruction is a load.
- branch_taken_exe  in  1  branch/jump resolved taken in EXE.
- dmem_req_mem  in  1  MEM-stage instruction accesses data memory (held by pipeline while stalled).
- dmem_ack  in  1  data-memory completion.
- stall_if, stall_id, stall_exe, stall_mem  out  1 each  hold the corresponding pipeline register.
- flush_id, flush_exe  out  1 each  load a bubble into the ID or EXE pipeline register.
- dmem_err  out  1  sticky timeout error.
- stall_cycles  out  CNT_W  cycles in which stall_if = 1.
- flush_count  out  CNT_W  number of taken-branch flushes.

## Operation

- **FSM states:** RUN, MEM_WAIT, ERR. Reset state is RUN.
- **Control outputs:** stall and flush outputs are combinational functions of the state and current inputs. All other outputs are registered.
- **Priority in RUN (highest first):**
  1. **Memory wait:** dmem_req_mem = 1 and dmem_ack = 0.
     - Assert all four stalls; both flushes = 0.
     - Next state MEM_WAIT; wait_cnt <= 1.
  2. **Branch:** branch_taken_exe = 1.
     - flush_id = flush_exe = 1; no stalls.
     - flush_count increments.
  3. **Load-use:** mem_read_exe = 1, rd_exe ≠ 0, and either (rs1_used_id and rs1_id == rd_exe) or (rs2_used_id and rs2_id == rd_exe).
     - stall_if = stall_id = 1 and flush_exe = 1.
     - Exactly one bubble is inserted per hazard.
  4. **Otherwise:** all stall and flush outputs are 0.
- **dmem_req_mem with dmem_ack in the same cycle:** zero-wait access, no stall. Branch and load-use rules still apply.
- **MEM_WAIT, dmem_ack = 1:**
  - All stalls = 0 in that cycle; the pipeline advances.
  - Next state RUN.
  - Branch and load-use rules are evaluated in that cycle exactly as in RUN.
- **MEM_WAIT, dmem_ack = 0:**
  - All stalls = 1.
  - If wait_cnt == DMEM_TIMEOUT − 1, next state is ERR. Otherwise wait_cnt increments.
  - Branch inputs are ignored; the branch is held in EXE and acted on once the wait ends.
- **ERR:**
  - All stalls = 1 and dmem_err = 1.
  - Exits only on reset_n.
- **wait_cnt:** ceil(log2(DMEM_TIMEOUT+1)) bits; internal only.
- **Counters:** stall_cycles and flush_count saturate at all-ones and never wrap.

## Timing

- **Reset values:** while reset_n = 0, every stall and flush output is forced to 0. Also: dmem_err = 0, stall_cycles = 0, flush_count = 0, state = RUN, wait_cnt = 0.
- **Reset assertion:** asynchronous; it takes effect immediately, including mid-MEM_WAIT or in ERR.
- **Reset release:** registers update from the first clk rising edge after reset_n goes high.
- **Stall/flush latency:** 0 cycles, same cycle as the causing inputs.
- **Memory-wait stall length:** a wait of N cycles (dmem_ack arrives N cycles after the request is first seen) gives exactly N stalled cycles, then one advancing cycle.
- **Timeout:** with no ack, the stalled cycles before entering ERR equal DMEM_TIMEOUT. dmem_err rises on the clock edge that ends the DMEM_TIMEOUT-th stalled cycle.
- **stall_cycles:** increments on the edge ending any cycle where stall_if = 1, including cycles spent in ERR.
- **flush_count:** increments on the edge ending a cycle where flush_id = 1 because of a branch.

## Test plan

- **Load-use:** lw x5 in EXE (rd_exe = 5, mem_read_exe = 1), ID reads rs1 = 5 → one cycle with stall_if = stall_id = flush_exe = 1, then all 0. stall_cycles = 1, flush_count = 0.
- **x0 and unused operand:** rd_exe = 0 with matching rs1, and separately rd_exe = 7 matching rs2_id with rs2_used_id = 0 → no stall in either case.
- **Branch vs load-use:** branch_taken_exe = 1 together with a load-use match → flush_id = flush_exe = 1, stall_if = 0, flush_count = 1.
- **Memory wait:** dmem_req_mem held with dmem_ack arriving on the 4th cycle → stalls high for 3 cycles, low on the ack cycle, state back to RUN, stall_cycles = 3. A same-cycle ack gives 0 stalls.
- **Timeout:** DMEM_TIMEOUT = 16, never ack → dmem_err = 1 after 16 stalled cycles. Stalls stay 1 indefinitely, and stall_cycles keeps counting.
- **Reset mid-wait:** reset_n pulsed low in MEM_WAIT and again in ERR → all outputs immediately 0. After release, normal RUN behaviour.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for load-use, taken-branch and multi-cycle dmem hazards.
// Also counts stall cycles and branch flushes and traps dmem handshake timeouts.
module hazard_stall_unit #(
  parameter int DMEM_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_exe,
  input  logic             mem_read_exe,
  input  logic             branch_taken_exe,
  input  logic             dmem_req_mem,
  input  logic             dmem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_exe,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_exe,
  output logic             dmem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(DMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;

  logic lu_hit;
  logic mem_miss;
  logic adv;
  logic br_flush;
  logic stall_all;

  assign mem_miss = dmem_req_mem & ~dmem_ack;

  assign lu_hit = mem_read_exe & (rd_exe != 5'd0) &
                  ((rs1_used_id & (rs1_id == rd_exe)) |
                   (rs2_used_id & (rs2_id == rd_exe)));

  always_comb begin
    adv       = 1'b0;
    stall_all = 1'b0;
    br_flush  = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_exe = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_exe = 1'b0;
    if (reset_n) begin
      unique case (state)
        RUN:      begin adv = ~mem_miss; stall_all = mem_miss;  end
        MEM_WAIT: begin adv = dmem_ack;  stall_all = ~dmem_ack; end
        ERR:      stall_all = 1'b1;
        default:  stall_all = 1'b0;
      endcase
    end
    // Branch beats load-use: the flushed ID instruction no longer matters.
    if (adv) begin
      priority case (1'b1)
        branch_taken_exe: begin
          br_flush  = 1'b1;
          flush_id  = 1'b1;
          flush_exe = 1'b1;
        end
        lu_hit: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          flush_exe = 1'b1;
        end
        default: ;
      endcase
    end
    if (stall_all) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_exe = 1'b1;
      stall_mem = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      dmem_err     <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_if && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (br_flush && !(&flush_count))
        flush_count <= flush_count + CNT_W'(1);
      unique case (state)
        RUN: begin
          if (mem_miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WC_LAST) begin
            state    <= ERR;
            dmem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit with a queue-based scoreboard.
// Driver pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_hazard_stall_unit;

  localparam int TO = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    rs1_id, rs2_id, rd_exe;
  logic          rs1_used_id, rs2_used_id;
  logic          mem_read_exe, branch_taken_exe;
  logic          dmem_req_mem, dmem_ack;
  logic          stall_if, stall_id, stall_exe, stall_mem;
  logic          flush_id, flush_exe, dmem_err;
  logic [CW-1:0] stall_cycles, flush_count;

  hazard_stall_unit #(.DMEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rs1_id           (rs1_id),
    .rs2_id           (rs2_id),
    .rs1_used_id      (rs1_used_id),
    .rs2_used_id      (rs2_used_id),
    .rd_exe           (rd_exe),
    .mem_read_exe     (mem_read_exe),
    .branch_taken_exe (branch_taken_exe),
    .dmem_req_mem     (dmem_req_mem),
    .dmem_ack         (dmem_ack),
    .stall_if         (stall_if),
    .stall_id         (stall_id),
    .stall_exe        (stall_exe),
    .stall_mem        (stall_mem),
    .flush_id         (flush_id),
    .flush_exe        (flush_exe),
    .dmem_err         (dmem_err),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [5:0]    ctrl;
    logic          err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // ctrl = {stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110001;
  localparam logic [5:0] C_BR   = 6'b000011;
  localparam logic [5:0] C_ALL  = 6'b111100;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] c;
      e = q.pop_front();
      c = {stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe};
      checks++;
      if (c !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl: got %b want %b", e.name, c, e.ctrl);
      end
      checks++;
      if (dmem_err !== e.err) begin
        errors++;
        $display("FAIL %s dmem_err: got %b want %b", e.name, dmem_err, e.err);
      end
      checks++;
      if (stall_cycles !== e.sc || flush_count !== e.fc) begin
        errors++;
        $display("FAIL %s counters: got sc=%0d fc=%0d want sc=%0d fc=%0d",
                 e.name, stall_cycles, flush_count, e.sc, e.fc);
      end
    end
  end

  task automatic step(
    input string      name,
    input logic       rst,
    input logic [4:0] r1, input logic u1,
    input logic [4:0] r2, input logic u2,
    input logic [4:0] rd, input logic mr,
    input logic       br,
    input logic       req, input logic ack,
    input logic [5:0] ec, input logic ee,
    input int         esc, input int efc
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset_n          = rst;
    rs1_id           = r1;
    rs1_used_id      = u1;
    rs2_id           = r2;
    rs2_used_id      = u2;
    rd_exe           = rd;
    mem_read_exe     = mr;
    branch_taken_exe = br;
    dmem_req_mem     = req;
    dmem_ack         = ack;
    e.name = name;
    e.ctrl = ec;
    e.err  = ee;
    e.sc   = CW'(esc);
    e.fc   = CW'(efc);
    q.push_back(e);
  endtask

  initial begin
    reset_n          = 1'b0;
    rs1_id           = '0;
    rs2_id           = '0;
    rd_exe           = '0;
    rs1_used_id      = 1'b0;
    rs2_used_id      = 1'b0;
    mem_read_exe     = 1'b0;
    branch_taken_exe = 1'b0;
    dmem_req_mem     = 1'b0;
    dmem_ack         = 1'b0;

    // name      rst r1 u1 r2 u2 rd mr br rq ak  ctrl   err sc fc
    step("rst_lu",   0, 5, 1, 0, 0, 5, 1, 0, 0, 0, C_NONE, 0, 0, 0);
    step("idle",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0);
    step("lu_rs1",   1, 5, 1, 0, 0, 5, 1, 0, 0, 0, C_LU,   0, 0, 0);
    step("lu_done",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 1, 0);
    step("x0",       1, 0, 1, 0, 0, 0, 1, 0, 0, 0, C_NONE, 0, 1, 0);
    step("rs2_off",  1, 0, 0, 7, 0, 7, 1, 0, 0, 0, C_NONE, 0, 1, 0);
    step("lu_rs2",   1, 0, 0, 7, 1, 7, 1, 0, 0, 0, C_LU,   0, 1, 0);
    step("br_lu",    1, 5, 1, 0, 0, 5, 1, 1, 0, 0, C_BR,   0, 2, 0);
    step("br_done",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 2, 1);
    step("mw1",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ALL,  0, 2, 1);
    step("mw2_br",   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_ALL,  0, 3, 1);
    step("mw3_br",   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_ALL,  0, 4, 1);
    step("mw_ack",   1, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_BR,   0, 5, 1);
    step("mw_done",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 5, 2);
    step("zw",       1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 0, 5, 2);
    step("zw_lu",    1, 3, 1, 0, 0, 3, 1, 0, 1, 1, C_LU,   0, 5, 2);
    step("zw_done",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 6, 2);
    step("mwa",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ALL,  0, 6, 2);
    step("mwa_lu",   1, 4, 0, 4, 1, 4, 1, 0, 1, 1, C_LU,   0, 7, 2);
    step("mwa_done", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 8, 2);
    step("mwb",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ALL,  0, 8, 2);
    step("rst_mw",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0, 0);
    step("rel1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0);
    step("post_lu",  1, 6, 1, 0, 0, 6, 1, 0, 0, 0, C_LU,   0, 0, 0);
    step("post_idl", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 1, 0);

    for (int i = 0; i < TO; i++)
      step($sformatf("to_%0d", i),
           1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ALL, 0, 1 + i, 0);

    // ERR ignores ack and branch; stall_cycles saturates at 31.
    for (int j = 0; j < 20; j++)
      step($sformatf("err_%0d", j),
           1, 0, 0, 0, 0, 0, 0, 1, 0, j[0], C_ALL, 1,
           (17 + j > 31) ? 31 : 17 + j, 0);

    step("rst_err",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0, 0);
    step("rel2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0);
    step("post_br",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,   0, 0, 0);
    step("post_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 1);

    for (int k = 0; k < 10 && q.size() > 0; k++)
      @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
